// File: rtl/blowfish_pkg.sv
// Shared Blowfish definitions: controller state encoding, table geometry and
// the S-box address helper used by both cipher directions.
package blowfish_pkg;

    localparam int N_ROUNDS_DEF = 16;
    localparam int P_LEN        = N_ROUNDS_DEF + 2;
    localparam int S_BOX_DEPTH  = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_F3,
        ST_PX,
        ST_FIN,
        ST_DONE
    } bf_state_e;

    // Flat S-box address: box number above an S_BOX_W-bit byte index.
    function automatic logic [31:0] sbox_addr(input logic [1:0] box,
                                              input logic [7:0] idx,
                                              input int unsigned sbw);
        return (32'(box) << sbw) | 32'(idx);
    endfunction

endpackage

// File: rtl/blowfish_feistel.sv
// Four-cycle sequential Blowfish F evaluator: one S-box read per cycle,
// F = ((S0 + S1) ^ S2) + S3 accumulated in r_acc, o_done one cycle after S3.
module blowfish_feistel
    import blowfish_pkg::*;
#(
    parameter int S_BOX_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_x,
    input  logic [31:0] i_s_data,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_f,
    output logic        o_done
);

    localparam int BW = $clog2(S_BOX_DEPTH);

    logic          r_act;
    logic [1:0]    r_step;
    logic [31:0]   r_acc;
    logic          r_done;

    logic          w_act;
    logic [1:0]    w_j;
    logic [BW-1:0] w_idx;
    logic [31:0]   w_acc;

    // i_start forces step 0 so an aborted evaluation never leaks into the next.
    assign w_act = i_start | r_act;
    assign w_j   = i_start ? 2'd0 : r_step;

    always_comb begin
        w_idx = i_x[31:24];
        w_acc = i_s_data;
        case (w_j)
            2'd0: begin w_idx = i_x[31:24]; w_acc = i_s_data;         end
            2'd1: begin w_idx = i_x[23:16]; w_acc = r_acc + i_s_data; end
            2'd2: begin w_idx = i_x[15:8];  w_acc = r_acc ^ i_s_data; end
            2'd3: begin w_idx = i_x[7:0];   w_acc = r_acc + i_s_data; end
            default: ;
        endcase
    end

    assign o_s_addr = w_act ? sbox_addr(w_j, w_idx, S_BOX_W) : 32'd0;
    assign o_f      = r_acc;
    assign o_done   = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act  <= 1'b0;
            r_step <= 2'd0;
            r_acc  <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_act && (w_j == 2'd3);
            if (w_act) begin
                r_acc  <= w_acc;
                r_step <= w_j + 2'd1;
                r_act  <= (w_j != 2'd3);
            end
        end
    end

endmodule

// File: rtl/blowfish_decipher.sv
// Blowfish block decryption over shared P/S table ports, 5 cycles per round.
// Optional BLOWFISH_DEC_ABORT_EN adds an abort input that drops back to IDLE.
module blowfish_decipher
    import blowfish_pkg::*;
#(
    parameter int N_ROUNDS = P_LEN - 2,
    parameter int S_BOX_W  = 8
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
`ifdef BLOWFISH_DEC_ABORT_EN
    input  logic        abort,
`endif
    input  logic [31:0] xl_in,
    input  logic [31:0] xr_in,
    input  logic [31:0] S_data,
    output logic [31:0] S_addr,
    input  logic [31:0] P_data,
    output logic [31:0] P_addr,
    output logic [31:0] xl_out,
    output logic [31:0] xr_out,
    output logic        busy,
    output logic        done
);

    localparam int KW = $clog2(N_ROUNDS + 1);

    bf_state_e   r_state;
    logic [31:0] r_a, r_b, r_xl, r_xr;
    logic [KW-1:0] r_k;
    logic        r_busy, r_done;

    logic        w_abort, w_kill, w_f_done;
    logic [31:0] w_f, w_src, w_p_addr;

`ifdef BLOWFISH_DEC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif
    assign w_kill = w_abort && (r_state != ST_IDLE);

    // Odd rounds take F of A and update B; even rounds the reverse.
    assign w_src = r_k[0] ? r_a : r_b;

    blowfish_feistel #(.S_BOX_W(S_BOX_W)) u_feistel (
        .i_clk    (clk),
        .i_rst    (reset_l | w_kill),
        .i_start  (r_state == ST_F0),
        .i_x      (w_src),
        .i_s_data (S_data),
        .o_s_addr (S_addr),
        .o_f      (w_f),
        .o_done   (w_f_done)
    );

    always_comb begin
        w_p_addr = 32'd0;
        case (r_state)
            ST_IDLE: if (start) w_p_addr = 32'(N_ROUNDS + 1);
            ST_PX:   w_p_addr = 32'(N_ROUNDS + 1) - 32'(r_k);
            default: ;
        endcase
    end

    assign P_addr = w_p_addr;
    assign xl_out = r_xl;
    assign xr_out = r_xr;
    assign busy   = r_busy;
    assign done   = r_done;

    always_ff @(posedge clk) begin
        if (reset_l) begin
            r_state <= ST_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_k     <= '0;
            r_xl    <= 32'd0;
            r_xr    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_kill) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a     <= xl_in ^ P_data;
                    r_b     <= xr_in;
                    r_k     <= KW'(1);
                    r_busy  <= 1'b1;
                    r_state <= ST_F0;
                end
                ST_F0: r_state <= ST_F1;
                ST_F1: r_state <= ST_F2;
                ST_F2: r_state <= ST_F3;
                ST_F3: r_state <= ST_PX;
                ST_PX: begin
                    if (w_f_done) begin
                        if (r_k[0]) r_b <= r_b ^ w_f ^ P_data;
                        else        r_a <= r_a ^ w_f ^ P_data;
                    end
                    if (r_k == KW'(N_ROUNDS)) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_k     <= r_k + KW'(1);
                        r_state <= ST_F0;
                    end
                end
                ST_FIN: begin
                    r_xl    <= r_b ^ P_data;
                    r_xr    <= r_a;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish_decipher.sv
// Bench for blowfish_decipher: known-answer table vectors, random round trips
// against a standard Blowfish encipher model, and start/reset corner sequences.
module tb_blowfish_decipher;

    logic        clk = 1'b0;
    logic        reset_l, start, abort;
    logic [31:0] xl_in, xr_in, S_data, S_addr, P_data, P_addr, xl_out, xr_out;
    logic        busy, done;

    logic [31:0] P_mem [0:17];
    logic [31:0] S_mem [0:3][0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blowfish_decipher dut (
        .clk     (clk),
        .reset_l (reset_l),
        .start   (start),
`ifdef BLOWFISH_DEC_ABORT_EN
        .abort   (abort),
`endif
        .xl_in   (xl_in),
        .xr_in   (xr_in),
        .S_data  (S_data),
        .S_addr  (S_addr),
        .P_data  (P_data),
        .P_addr  (P_addr),
        .xl_out  (xl_out),
        .xr_out  (xr_out),
        .busy    (busy),
        .done    (done)
    );

    // Combinational key-table memories.
    assign P_data = (P_addr < 32'd18) ? P_mem[P_addr[4:0]] : 32'hDEAD_BEEF;
    assign S_data = S_mem[S_addr[9:8]][S_addr[7:0]];

    typedef struct {
        int          kind;
        logic [31:0] xl, xr, el, er;
    } vec_t;

    function automatic logic [31:0] f_ref(input logic [31:0] x);
        return ((S_mem[0][x[31:24]] + S_mem[1][x[23:16]]) ^ S_mem[2][x[15:8]]) + S_mem[3][x[7:0]];
    endfunction

    // Textbook 16-round Blowfish encryption.
    function automatic logic [63:0] encipher(input logic [31:0] l_i, input logic [31:0] r_i);
        logic [31:0] l, r, t;
        l = l_i;
        r = r_i;
        for (int i = 0; i < 16; i++) begin
            l = l ^ P_mem[i];
            r = r ^ f_ref(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ P_mem[16];
        l = l ^ P_mem[17];
        return {l, r};
    endfunction

    // kind 0: all zero; kind 1: P[i]=1<<i, S zero; kind 2: random.
    task automatic load_tables(input int kind);
        for (int i = 0; i < 18; i++)
            P_mem[i] = (kind == 0) ? 32'd0 : (kind == 1) ? (32'd1 << i) : $urandom;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 256; i++)
                S_mem[b][i] = (kind == 2) ? $urandom : 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_p(input int c);
        if (c >= 5 && c <= 80 && (c % 5) == 0) return 32'(17 - c / 5);
        return 32'd0;
    endfunction

    function automatic bit s_ok(input int c);
        if (c >= 1 && c <= 80 && ((c - 1) % 5) < 4)
            return (S_addr[31:10] == 22'd0) && (S_addr[9:8] == 2'((c - 1) % 5));
        return S_addr == 32'd0;
    endfunction

    // One operation from an idle DUT; returns outputs, done latency and a
    // flag covering address order, busy and output hold. bad_c = first bad cycle.
    task automatic run_op(input logic [31:0] l, input logic [31:0] r,
                          output logic [31:0] ol, output logic [31:0] orr,
                          output int lat, output int bad_c);
        logic [31:0] pl, pr;
        @(negedge clk);
        pl = xl_out;
        pr = xr_out;
        xl_in = l;
        xr_in = r;
        start = 1'b1;
        #1;
        bad_c = -1;
        if (P_addr != 32'd17 || S_addr != 32'd0 || busy) bad_c = 0;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (bad_c < 0 && (!busy || P_addr != exp_p(c) || !s_ok(c) ||
                              (c <= 81 && (xl_out != pl || xr_out != pr))))
                bad_c = c;
            @(negedge clk);
        end
        ol = xl_out;
        orr = xr_out;
    endtask

    task automatic check_op(input string tag, input logic [31:0] l, input logic [31:0] r,
                            input logic [31:0] el, input logic [31:0] er);
        logic [31:0] ol, orr;
        int lat, bad_c;
        run_op(l, r, ol, orr, lat, bad_c);
        chk({tag, "_xl"}, ol, el);
        chk({tag, "_xr"}, orr, er);
        chk({tag, "_latency"}, 32'(lat), 32'd82);
        chk({tag, "_seq_first_bad_cycle"}, 32'(bad_c), 32'hFFFF_FFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [63:0] ct, ct2;
        logic [31:0] pl, pr, pl2, pr2, rl, rr;
        int n_done, done_c, done_c2, busy_bad, lat, bad_c;

        vecs[0] = '{0, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h01234567};
        vecs[1] = '{0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{0, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[3] = '{1, 32'h00000000, 32'h00000000, 32'h00015555, 32'h0002AAAA};
        vecs[4] = '{1, 32'hFFFFFFFF, 32'h12345678, 32'h1235032D, 32'hFFFD5555};
        vecs[5] = '{1, 32'h0002AAAA, 32'h00015555, 32'h00000000, 32'h00000000};

        reset_l = 1'b1; start = 1'b0; abort = 1'b0;
        xl_in = 32'd0; xr_in = 32'd0;
        load_tables(0);
        repeat (3) @(negedge clk);
        reset_l = 1'b0;
        @(negedge clk);
        chk("reset_xl", xl_out, 32'd0);
        chk("reset_xr", xr_out, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_paddr", P_addr, 32'd0);
        chk("reset_saddr", S_addr, 32'd0);

        for (int i = 0; i < 6; i++) begin
            load_tables(vecs[i].kind);
            check_op($sformatf("vec%0d", i), vecs[i].xl, vecs[i].xr, vecs[i].el, vecs[i].er);
        end

        for (int i = 0; i < 100; i++) begin
            if (i % 25 == 0) load_tables(2);
            pl = $urandom;
            pr = $urandom;
            ct = encipher(pl, pr);
            check_op($sformatf("rand%0d", i), ct[63:32], ct[31:0], pl, pr);
        end

        // Second start while busy (offset 30 cycles) must be ignored.
        pl = $urandom; pr = $urandom; ct = encipher(pl, pr);
        pl2 = ~pl; pr2 = pr ^ 32'h5A5A5A5A; ct2 = encipher(pl2, pr2);
        @(negedge clk);
        xl_in = ct[63:32]; xr_in = ct[31:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; done_c = -1; busy_bad = -1;
        for (int c = 1; c <= 110; c++) begin
            if (c == 30) begin xl_in = ct2[63:32]; xr_in = ct2[31:0]; start = 1'b1; end
            if (c == 31) start = 1'b0;
            if (done) begin
                n_done++;
                done_c = c;
                rl = xl_out; rr = xr_out;
            end
            if (busy_bad < 0 && busy != (c <= 82)) busy_bad = c;
            @(negedge clk);
        end
        chk("ignore_done_count", 32'(n_done), 32'd1);
        chk("ignore_done_cycle", 32'(done_c), 32'd82);
        chk("ignore_xl", rl, pl);
        chk("ignore_xr", rr, pr);
        chk("ignore_busy_first_bad_cycle", 32'(busy_bad), 32'hFFFF_FFFF);

        // start held high: back-to-back operations, second takes new data.
        @(negedge clk);
        xl_in = ct[63:32]; xr_in = ct[31:0]; start = 1'b1;
        @(negedge clk);
        done_c = -1; done_c2 = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c == 5) begin xl_in = ct2[63:32]; xr_in = ct2[31:0]; end
            if (done) begin
                if (done_c < 0) begin
                    done_c = c; rl = xl_out; rr = xr_out;
                end else begin
                    done_c2 = c; start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_done1_cycle", 32'(done_c), 32'd82);
        chk("b2b_xl1", rl, pl);
        chk("b2b_xr1", rr, pr);
        chk("b2b_done2_cycle", 32'(done_c2), 32'd165);
        chk("b2b_xl2", xl_out, pl2);
        chk("b2b_xr2", xr_out, pr2);

        // Reset at cycle 30 of an operation, fresh start at cycle 32.
        @(negedge clk);
        @(negedge clk);
        xl_in = ct2[63:32]; xr_in = ct2[31:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c < 30; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        reset_l = 1'b1;
        @(negedge clk);
        if (done) n_done++;
        chk("midreset_no_done", 32'(n_done), 32'd0);
        chk("midreset_xl", xl_out, 32'd0);
        chk("midreset_xr", xr_out, 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        reset_l = 1'b0;
        run_op(ct[63:32], ct[31:0], rl, rr, lat, bad_c);
        chk("after_reset_xl", rl, pl);
        chk("after_reset_xr", rr, pr);
        chk("after_reset_latency", 32'(lat), 32'd82);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
